// File: rtl/eth_led_monitor.sv
// eth_led_monitor: debug LED monitor for a GMII-style byte stream.
// Shows one of four views on an LED bank: last byte, frame count,
// last frame length (clipped to the bank), or stretched activity/error.
//
// Stream handshake: valid qualifies data and err in the same cycle. There is
// no backpressure (no ready); every cycle with valid=1 is consumed. A
// contiguous run of valid=1 is one frame; err is ignored when valid=0.
module eth_led_monitor #(
  parameter int DATA_W         = 8,
  parameter int LED_W          = 8,
  parameter int LEN_W          = 16,
  parameter int STRETCH_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              err,
  input  logic [1:0]        mode,
  input  logic              clear,
  output logic [LED_W-1:0]  leds
);

  localparam int CNT_W = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam int MIN_W = (DATA_W < LED_W) ? DATA_W : LED_W;

  localparam logic [1:0]       MODE_LATCH    = 2'd0;
  localparam logic [1:0]       MODE_FRAMES   = 2'd1;
  localparam logic [1:0]       MODE_LENGTH   = 2'd2;
  localparam logic [1:0]       MODE_ACTIVITY = 2'd3;

  localparam logic [CNT_W-1:0] STRETCH     = CNT_W'(STRETCH_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX     = '1;
  localparam logic [LEN_W-1:0] LEN_LED_MAX = LEN_W'({LED_W{1'b1}});

  logic              valid_q;
  logic              sof;
  logic              eof;
  logic [LED_W-1:0]  data_ext;
  logic [LED_W-1:0]  latch_r;
  logic [LED_W-1:0]  frame_cnt;
  logic [LEN_W-1:0]  len_cnt;
  logic [LED_W-1:0]  len_r;
  logic [LED_W-1:0]  len_clip;
  logic [CNT_W-1:0]  act_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              sticky_err;
  logic [LED_W-1:0]  act_leds;

  assign sof = valid & ~valid_q;
  assign eof = ~valid & valid_q;

  // Low LED_W bits of the byte, zero-extended when the bank is wider.
  always_comb begin
    data_ext = '0;
    for (int i = 0; i < MIN_W; i++) data_ext[i] = data[i];
  end

  // Frame length clipped to what the LED bank can display.
  always_comb begin
    len_clip = (len_cnt > LEN_LED_MAX) ? {LED_W{1'b1}} : len_cnt[LED_W-1:0];
  end

  // Activity view: stretched activity, stretched error, sticky error.
  always_comb begin
    act_leds    = '0;
    act_leds[0] = (act_cnt != '0);
    act_leds[1] = (err_cnt != '0);
    act_leds[2] = sticky_err;
  end

  // valid_q keeps tracking valid through clear so a running frame is not re-seen as sof.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) valid_q <= 1'b0;
    else          valid_q <= valid;
  end

  // Last byte seen.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   latch_r <= '0;
    else if (clear) latch_r <= '0;
    else if (valid) latch_r <= data_ext;
  end

  // Frame counter, wraps naturally at LED_W bits.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   frame_cnt <= '0;
    else if (clear) frame_cnt <= '0;
    else if (sof)   frame_cnt <= frame_cnt + LED_W'(1);
  end

  // Running length; held at 0 after a mid-frame clear until the next sof.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   len_cnt <= '0;
    else if (clear) len_cnt <= '0;
    else if (sof)   len_cnt <= LEN_W'(1);
    else if (valid && (len_cnt != '0) && (len_cnt != LEN_MAX))
                    len_cnt <= len_cnt + LEN_W'(1);
  end

  // Length of the last completed frame, captured at eof.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   len_r <= '0;
    else if (clear) len_r <= '0;
    else if (eof)   len_r <= len_clip;
  end

  // Activity and error pulse stretchers; a new event reloads to the full duration.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      act_cnt    <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (clear) begin
      act_cnt    <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else begin
      if (valid)              act_cnt <= STRETCH;
      else if (act_cnt != '0) act_cnt <= act_cnt - CNT_W'(1);
      if (valid && err)       err_cnt <= STRETCH;
      else if (err_cnt != '0) err_cnt <= err_cnt - CNT_W'(1);
      if (valid && err)       sticky_err <= 1'b1;
    end
  end

  // Registered output select; mode only chooses the view, never touches state.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)   leds <= '0;
    else if (clear) leds <= '0;
    else begin
      case (mode)
        MODE_LATCH:    leds <= latch_r;
        MODE_FRAMES:   leds <= frame_cnt;
        MODE_LENGTH:   leds <= len_r;
        MODE_ACTIVITY: leds <= act_leds;
        default:       leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_led_monitor.sv
// Testbench for eth_led_monitor: directed stimulus, expected LED values
// queued with the cycle at which they must appear, checked by a monitor.
module tb_eth_led_monitor;

  localparam int DATA_W  = 8;
  localparam int LED_W   = 8;
  localparam int LEN_W   = 16;
  localparam int STRETCH = 4;

  // clock / reset
  logic              clk = 1'b0;
  logic              aresetn;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              err;
  logic [1:0]        mode;
  logic              clear;
  logic [LED_W-1:0]  leds;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_led_monitor #(
    .DATA_W(DATA_W), .LED_W(LED_W), .LEN_W(LEN_W), .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk(clk), .aresetn(aresetn), .data(data), .valid(valid), .err(err),
    .mode(mode), .clear(clear), .leds(leds)
  );

  // scoreboard
  logic [LED_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  string            exp_tag_q[$];
  int total = 0;
  int bad   = 0;

  task automatic expect_at(input int at, input logic [LED_W-1:0] v, input string tag);
    exp_q.push_back(v);
    exp_cyc_q.push_back(at);
    exp_tag_q.push_back(tag);
  endtask

  // monitor: compares on the falling edge, away from the active edge
  initial begin : monitor
    logic [LED_W-1:0] m_exp;
    int               m_cyc;
    string            m_tag;
    forever begin
      @(negedge clk);
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        m_exp = exp_q.pop_front();
        m_cyc = exp_cyc_q.pop_front();
        m_tag = exp_tag_q.pop_front();
        total++;
        if (m_cyc != cyc) begin
          bad++;
          $display("FAIL %s: check due at cycle %0d not reached until %0d", m_tag, m_cyc, cyc);
        end else if (leds !== m_exp) begin
          bad++;
          $display("FAIL %s: cycle %0d leds=0x%02h expected 0x%02h", m_tag, cyc, leds, m_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic e);
    valid = v;
    data  = d;
    err   = e;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int lens[3]  = '{60, 300, 1};
  int lexp[3]  = '{60, 255, 1};
  int lprev[3] = '{1, 60, 255};
  int p, c, d, f, g, b;

  initial begin : stimulus
    aresetn = 1'b0;
    drive(1'b0, '0, 1'b0);
    mode  = 2'd0;
    clear = 1'b0;

    // 1: reset mid-stream
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
    p = cyc;
    drive(1'b1, 8'h5A, 1'b0);
    expect_at(p + 2, 8'h5A, "t1_latch_5a");
    tick();
    drive(1'b1, 8'h5B, 1'b0);
    expect_at(p + 3, 8'h5B, "t1_latch_5b");
    repeat (3) tick();
    #2;
    aresetn = 1'b0;
    expect_at(cyc, 8'h00, "t1_async_reset");
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    aresetn = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      expect_at(cyc + 1, 8'h00, "t1_post_reset_mode");
      tick();
    end

    // 2: latch mode, three bytes then idle
    mode = 2'd0;
    c = cyc;
    drive(1'b1, 8'h11, 1'b0); expect_at(c + 2, 8'h11, "t2_byte0"); tick();
    drive(1'b1, 8'h22, 1'b0); expect_at(c + 3, 8'h22, "t2_byte1"); tick();
    drive(1'b1, 8'hA5, 1'b0); expect_at(c + 4, 8'hA5, "t2_byte2");
    expect_at(c + 5, 8'hA5, "t2_hold1");
    expect_at(c + 7, 8'hA5, "t2_hold3");
    tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (5) tick();

    // 3: frame count over 257 one-byte frames
    clear = 1'b1;
    mode  = 2'd1;
    expect_at(cyc + 1, 8'h00, "t3_clear");
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      expect_at(cyc + 2, 8'(i), "t3_frame_cnt");
      tick();
      drive(1'b0, 8'h00, 1'b0);
      tick();
    end
    tick();

    // 4: frame length 60, 300 (clipped), 1
    mode = 2'd2;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < lens[k]; i++) begin
        drive(1'b1, 8'(i), 1'b0);
        tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      expect_at(cyc + 1, 8'(lprev[k]), "t4_len_before_eof");
      expect_at(cyc + 2, 8'(lexp[k]), "t4_len_after_eof");
      repeat (3) tick();
    end

    // 5: activity / error stretch, err without valid, clear, retrigger
    clear = 1'b1;
    mode  = 2'd3;
    expect_at(cyc + 1, 8'h00, "t5_clear_start");
    tick();
    clear = 1'b0;
    tick();
    c = cyc;
    drive(1'b1, 8'h00, 1'b1);
    expect_at(c + 1, 8'h00, "t5_before");
    for (int j = 2; j <= 5; j++) expect_at(c + j, 8'h07, "t5_stretch_on");
    expect_at(c + 6, 8'h04, "t5_stretch_off");
    expect_at(c + 7, 8'h04, "t5_sticky_hold");
    tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (7) tick();
    d = cyc;
    drive(1'b0, 8'hFF, 1'b1);
    for (int j = 1; j <= 3; j++) expect_at(d + j, 8'h04, "t5_err_no_valid");
    tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) tick();
    f = cyc;
    clear = 1'b1;
    expect_at(f + 1, 8'h00, "t5_clear_leds");
    expect_at(f + 2, 8'h00, "t5_clear_sticky");
    tick();
    clear = 1'b0;
    tick();
    g = cyc;
    drive(1'b1, 8'h10, 1'b0);
    expect_at(g + 1, 8'h00, "t5_retrig_before");
    for (int j = 2; j <= 7; j++) expect_at(g + j, 8'h01, "t5_retrig_on");
    expect_at(g + 8, 8'h00, "t5_retrig_off");
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, 8'h11, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (7) tick();

    // 6: clear coinciding with sof, then mode switch mid-frame
    c = cyc;
    mode  = 2'd1;
    clear = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    expect_at(c + 1, 8'h00, "t6_clear_sof");
    tick();
    clear = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 8'(8'h77 + k), 1'b0);
      expect_at(cyc + 1, 8'h00, "t6_no_resof");
      tick();
    end
    mode = 2'd2;
    drive(1'b0, 8'h00, 1'b0);
    expect_at(c + 5, 8'h00, "t6_len_pre_eof");
    expect_at(c + 6, 8'h00, "t6_len_after_clear_frame");
    repeat (3) tick();
    b = cyc;
    mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h31 + i), 1'b0);
      if (i == 1) expect_at(b + 2, 8'h00, "t6_len_mid_frame");
      if (i == 2) begin
        mode = 2'd0;
        expect_at(b + 3, 8'h32, "t6_mode_switch_latch");
      end
      if (i == 3) expect_at(b + 4, 8'h33, "t6_latch_follow");
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    mode = 2'd2;
    expect_at(b + 6, 8'h00, "t6_len_before_eof");
    expect_at(b + 7, 8'h05, "t6_len_after_eof");
    repeat (4) tick();

    // final report
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks left pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
